// File: rtl/alu_share_arbiter_pkg.sv
// alu_pkg: ALUOp encodings, datapath widths, FSM state encoding and the
// legal-opcode helper shared by the arbiter and its optional opcode check
// (enabled with ALU_ARB_OPCHK_EN).
package alu_pkg;

    localparam int ALU_DATA_W = 64;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // True for the five encodings the ALU actually implements.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for alu_share_arbiter: two request ports, the registered ALU
// operand/opcode outputs, the combinational ALU return path and the tagged
// response. rsp_illegal exists only when ALU_ARB_OPCHK_EN is defined.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              busy;
`ifdef ALU_ARB_OPCHK_EN
    logic              rsp_illegal;
`endif

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        output busy
`ifdef ALU_ARB_OPCHK_EN
        , output rsp_illegal
`endif
    );

    // Requester / ALU / response-consumer side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  busy
`ifdef ALU_ARB_OPCHK_EN
        , input rsp_illegal
`endif
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. On contention the requester that did
// not win last time is chosen; last_grant resets to 1 so requester 0 wins
// the first contended grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic       grant_valid,
    output logic       grant_id
);
    logic last_grant_q;
    logic last_grant_d;

    // Pick the winner and compute the next last_grant.
    always_comb begin
        grant_valid  = |req;
        grant_id     = 1'b0;
        last_grant_d = last_grant_q;
        if (req == 2'b11) begin
            grant_id = ~last_grant_q;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
        if (update_en && grant_valid) begin
            last_grant_d = grant_id;
        end
    end

    // last_grant register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 64-bit ALU between two
// requesters. Accept in cycle T, operands on the ALU in T+1, response pulse
// in T+2. Optional opcode check under ALU_ARB_OPCHK_EN adds rsp_illegal and
// forces result 0 / zero 1 for unsupported opcodes.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus
);
    // Handshake: reqN_ready is combinational and high only in IDLE while
    // requester N holds valid and wins arbitration; a transfer happens on
    // valid && ready. Requesters keep valid/a/b/op stable until ready and may
    // withdraw valid before ready without leaving any state behind.

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              win_id_q, win_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
`ifdef ALU_ARB_OPCHK_EN
    logic              rsp_illegal_q, rsp_illegal_d;
    logic              op_illegal;
`endif

    logic grant_valid;
    logic grant_id;
    logic arb_en;

    assign arb_en = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         ({bus.req1_valid, bus.req0_valid}),
        .update_en   (arb_en),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign bus.req0_ready = arb_en && grant_valid && !grant_id;
    assign bus.req1_ready = arb_en && grant_valid &&  grant_id;

    // Next-state and datapath capture; registers hold unless updated.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        win_id_d     = win_id_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
`ifdef ALU_ARB_OPCHK_EN
        rsp_illegal_d = rsp_illegal_q;
        op_illegal    = !is_legal_op(alu_op_q);
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    alu_a_d  = grant_id ? bus.req1_a  : bus.req0_a;
                    alu_b_d  = grant_id ? bus.req1_b  : bus.req0_b;
                    alu_op_d = grant_id ? bus.req1_op : bus.req0_op;
                    win_id_d = grant_id;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = win_id_q;
                rsp_result_d = bus.alu_result;
                rsp_zero_d   = bus.alu_zero;
`ifdef ALU_ARB_OPCHK_EN
                rsp_illegal_d = op_illegal;
                if (op_illegal) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b1;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            win_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            rsp_illegal_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            win_id_q     <= win_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_OPCHK_EN
            rsp_illegal_q <= rsp_illegal_d;
`endif
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.busy       = (state_q != IDLE);
`ifdef ALU_ARB_OPCHK_EN
    assign bus.rsp_illegal = rsp_illegal_q;
`endif

endmodule
